// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file port arbiter.
package regfile_pkg;

  localparam int ADDR_W   = 6;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 64;

  typedef struct packed {
    logic              Write;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] WData;
  } rf_req_t;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_DBG  = 1'b1
  } req_id_t;

endpackage

// File: rtl/regfile_arb_pick.sv
// Combinational two-way grant decision between the core and debug requesters.
module regfile_arb_pick
  import regfile_pkg::*;
(
  input  logic [1:0] Req,
  input  logic [1:0] Write,
  input  logic       Ptr,
  output logic [1:0] Gnt,
  output logic       DualRead,
  output logic       Conflict,
  output logic       Loser
);

  logic bothReq;

  assign bothReq  = Req[REQ_CORE] & Req[REQ_DBG];
  assign DualRead = bothReq & ~Write[REQ_CORE] & ~Write[REQ_DBG];
  assign Conflict = bothReq & (Write[REQ_CORE] | Write[REQ_DBG]);
  assign Loser    = ~Ptr;

  // Outside a conflict every requester that asks is served.
  always_comb begin
    Gnt = Req;
    if (Conflict) begin
      Gnt = Ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Arbitrates the shared 64x16 register file between core and debug requesters,
// registering read responses and counting denied cycles.
module regfile_port_arbiter
  import regfile_pkg::*;
(
  input  logic              Clock,
  input  logic              nReset,
  input  logic [1:0]        Req,
  input  logic [1:0]        Write,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData0,
  input  logic [DATA_W-1:0] WData1,
  output logic [1:0]        Gnt,
  output logic [1:0]        RValid,
  output logic [DATA_W-1:0] RData0,
  output logic [DATA_W-1:0] RData1,
  output logic [15:0]       ConflictCount,
  output logic [ADDR_W-1:0] AddressA,
  output logic [ADDR_W-1:0] AddressB,
  output logic [DATA_W-1:0] WriteData,
  output logic              WriteEnable,
  input  logic [DATA_W-1:0] ReadDataA,
  input  logic [DATA_W-1:0] ReadDataB
);

  logic       Ptr;
  logic [1:0] pickGnt;
  logic       DualRead;
  logic       Conflict;
  logic       Loser;
  rf_req_t    reqs [2];

  assign reqs[REQ_CORE] = '{Write: Write[REQ_CORE], Addr: Addr0, WData: WData0};
  assign reqs[REQ_DBG]  = '{Write: Write[REQ_DBG],  Addr: Addr1, WData: WData1};

  regfile_arb_pick uPick (
    .Req      (Req),
    .Write    (Write),
    .Ptr      (Ptr),
    .Gnt      (pickGnt),
    .DualRead (DualRead),
    .Conflict (Conflict),
    .Loser    (Loser)
  );

  // Grants are suppressed combinationally for the whole time reset is held.
  assign Gnt = nReset ? pickGnt : 2'b00;

  // NOTE: every output of a combinational block is given a default first so
  // that no path leaves it unassigned and a latch gets inferred.
  always_comb begin
    AddressA    = '0;
    AddressB    = '0;
    WriteData   = '0;
    WriteEnable = 1'b0;
    if (Gnt[REQ_CORE]) begin
      AddressA = reqs[REQ_CORE].Addr;
      if (reqs[REQ_CORE].Write) begin
        WriteData   = reqs[REQ_CORE].WData;
        WriteEnable = 1'b1;
      end
    end
    if (Gnt[REQ_DBG]) begin
      if (DualRead) begin
        AddressB = reqs[REQ_DBG].Addr;
      end else begin
        AddressA = reqs[REQ_DBG].Addr;
        if (reqs[REQ_DBG].Write) begin
          WriteData   = reqs[REQ_DBG].WData;
          WriteEnable = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      Ptr           <= REQ_CORE;
      RValid        <= 2'b00;
      RData0        <= '0;
      RData1        <= '0;
      ConflictCount <= '0;
    end else begin
      RValid <= Gnt & ~Write;
      if (Gnt[REQ_CORE] && !Write[REQ_CORE]) begin
        RData0 <= ReadDataA;
      end
      if (Gnt[REQ_DBG] && !Write[REQ_DBG]) begin
        RData1 <= DualRead ? ReadDataB : ReadDataA;
      end
      if (Conflict) begin
        Ptr <= Loser;
        if (ConflictCount != 16'hFFFF) begin
          ConflictCount <= ConflictCount + 16'd1;
        end
      end
    end
  end

endmodule

// File: doc/regfile_port_arbiter.md
# regfile_port_arbiter

Shares the 64×16 register file between two requesters: requester 0 (core) and requester 1 (debug/DMA). Write port and read port A are addressed through AddressA, and read port B through AddressB. The arbiter grants per cycle, issues concurrent reads on both ports when possible, and serialises writes with a round-robin pointer. It registers read responses and counts denied cycles. The arbiter sits directly in front of the registerfile instance; the register file's contents and ports are unchanged.

## Interface
- ADDR_W, 6, register address width (64 registers)
- DATA_W, 16, register data width
- Clock  input  1  system clock, rising-edge
- nReset  input  1  reset, asynchronous, active-low
- Req[1:0]  input  2  per-requester request; payload held stable until granted
- Write[1:0]  input  2  per-requester op: 1 = write, 0 = read
- Addr0, Addr1  input  ADDR_W  per-requester register address
- WData0, WData1  input  DATA_W  per-requester write data
- Gnt[1:0]  output  2  per-requester grant; a transfer completes on a cycle with Req&Gnt
- RValid[1:0]  output  2  read response valid, one cycle pulse
- RData0, RData1  output  DATA_W  read response data
- ConflictCount  output  16  saturating count of requester-denied cycles
- AddressA, AddressB  output  ADDR_W  to registerfile
- WriteData  output  DATA_W  to registerfile
- WriteEnable  output  1  to registerfile
- ReadDataA, ReadDataB  input  DATA_W  from registerfile (combinational read)

## Operation
- **State:** priority pointer Ptr (0/1), RValid/RData registers, ConflictCount.
- **Single request:** only one Req high, so it is granted regardless of Ptr.
- **Dual read:** both Req high and both reads. Both are granted; AddressA=Addr0 and AddressB=Addr1; Ptr is unchanged.
- **Conflict:** both Req high with at least one write. Only Gnt[Ptr] is issued; afterwards Ptr := the loser and ConflictCount += 1, saturating at 16'hFFFF.
- **Write grant (requester i):** AddressA=Addr_i, WriteData=WData_i, WriteEnable=1.
- **Read grant:** requester 0 is served from port A, and requester 1 from port B when dual-reading. A lone requester-1 read uses port A.
- **Idle outputs:** with no grant, AddressA=AddressB=0, WriteData=0, WriteEnable=0.
- **No grant without request:** Gnt[i] is never high without Req[i].
- **Read-after-write:** a write granted in cycle N commits at the end of N. A read of the same address granted in N+1 returns the new value.

## Timing
- Gnt and the register-file drive signals are combinational from Req, Write and Ptr, within the same cycle.
- Read latency: a grant in cycle N gives RValid[i]=1 and RData_i = the captured ReadDataA/B in cycle N+1 only. RData holds its value after RValid falls.
- Back-to-back grants to the same requester are allowed every cycle.
- **Reset (nReset low, asynchronous):**
  - Ptr=0, RValid=0, RData0=RData1=0, ConflictCount=0.
  - Gnt=0 and WriteEnable=0 are forced combinationally while reset is asserted.
  - A read granted in the cycle before reset produces no response.
  - A write whose commit edge coincides with reset assertion is not guaranteed.
- Reset release takes effect at the first rising edge of Clock with nReset high.

## Structure
- Package regfile_pkg holds:
  - ADDR_W, DATA_W, NUM_REGS=64;
  - typedef struct rf_req_t {Write, Addr, WData};
  - typedef enum logic {REQ_CORE=0, REQ_DBG=1}.
- Sub-module regfile_arb_pick: purely combinational two-way decision. Inputs are Req, Write and Ptr; outputs are Gnt, DualRead, Conflict and Loser.
- Top level holds Ptr, response registers, counter and the port muxes.

## Test plan
- **Reset:** nReset=0 with Req=2'b11 -> Gnt=0, WriteEnable=0, RValid=0, ConflictCount=0.
- **Write then read, requester 0 alone:**
  - Write 16'h3D3A to addr 1 -> Gnt=2'b01, WriteEnable=1, AddressA=1 in the same cycle.
  - Next cycle, read addr 1 -> the following cycle RValid=2'b01 and RData0=16'h3D3A.
- **Dual read:** preload addr 6=16'h000A, then both requesters read (R0 addr 1, R1 addr 6) -> Gnt=2'b11, AddressB=6. Next cycle RData0=16'h3D3A, RData1=16'h000A, and ConflictCount is unchanged.
- **Write conflict after reset:** R0 writes 16'h1111 to addr 2 and R1 writes 16'h2222 to addr 3, each dropping Req once granted.
  - Cycle 1: Gnt=2'b01.
  - Cycle 2: Gnt=2'b10.
  - Result: ConflictCount=1; reads return 1111 and 2222.
- **Sustained conflict:** both hold write requests for 6 cycles -> Gnt alternates 01,10,01,10,01,10 and ConflictCount=6.
- **Reset mid-read:** R1 read is granted, then nReset drops before the next edge -> RValid stays 0, and after release Ptr=0 (R0 wins the first conflict).
